// File: rtl/mbist_pkg.sv
// Shared MBIST definitions: controller state encoding and march pattern count.
// Imported by the controller and by the downstream pattern decoder.
package mbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } mbist_state_t;

    localparam int          NUM_PATTERNS = 6;
    localparam logic [2:0]  LAST_Q       = 3'(NUM_PATTERNS - 1);

endpackage

// File: rtl/mbist_controller.sv
// MBIST sequencer: per pattern, write all addresses, read all back, flush the last compare.
// Every output is a register; start is only sampled in IDLE/DONE, so it is ignored while busy.
module mbist_controller
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mismatch,
    output logic [2:0]        q,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic              re,
    output logic              cmp_en,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_q
);

    mbist_state_t      r_state, w_state_nxt;
    logic [2:0]        r_q, w_q_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              r_we, w_we_nxt;
    logic              r_re, w_re_nxt;
    logic              r_cmp_en;
    logic [ADDR_W-1:0] r_cmp_addr;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_fail, w_fail_nxt;
    logic [ADDR_W-1:0] r_fail_addr, w_fail_addr_nxt;
    logic [2:0]        r_fail_q, w_fail_q_nxt;
    logic              w_addr_last;

    assign w_addr_last = &r_addr;

    always_comb begin
        w_state_nxt     = r_state;
        w_q_nxt         = r_q;
        w_addr_nxt      = r_addr;
        w_we_nxt        = 1'b0;
        w_re_nxt        = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_fail_nxt      = r_fail;
        w_fail_addr_nxt = r_fail_addr;
        w_fail_q_nxt    = r_fail_q;

        // r_q still names the pattern under compare, including the FLUSH cycle
        if (r_cmp_en && mismatch && !r_fail) begin
            w_fail_nxt      = 1'b1;
            w_fail_addr_nxt = r_cmp_addr;
            w_fail_q_nxt    = r_q;
        end

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt     = ST_WRITE;
                    w_q_nxt         = 3'd0;
                    w_addr_nxt      = '0;
                    w_we_nxt        = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_fail_nxt      = 1'b0;
                    w_fail_addr_nxt = '0;
                    w_fail_q_nxt    = 3'd0;
                end
            end
            ST_WRITE: begin
                w_busy_nxt = 1'b1;
                if (w_addr_last) begin
                    w_state_nxt = ST_READ;
                    w_addr_nxt  = '0;
                    w_re_nxt    = 1'b1;
                end else begin
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_we_nxt    = 1'b1;
                end
            end
            ST_READ: begin
                w_busy_nxt = 1'b1;
                if (w_addr_last) begin
                    w_state_nxt = ST_FLUSH;
                end else begin
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_re_nxt    = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (r_q == LAST_Q) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_WRITE;
                    w_q_nxt     = r_q + 3'd1;
                    w_addr_nxt  = '0;
                    w_we_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_q         <= 3'd0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_cmp_en    <= 1'b0;
            r_cmp_addr  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_q    <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_q         <= w_q_nxt;
            r_addr      <= w_addr_nxt;
            r_we        <= w_we_nxt;
            r_re        <= w_re_nxt;
            r_cmp_en    <= r_re;
            r_cmp_addr  <= r_addr;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_fail      <= w_fail_nxt;
            r_fail_addr <= w_fail_addr_nxt;
            r_fail_q    <= w_fail_q_nxt;
        end
    end

    assign q         = r_q;
    assign addr      = r_addr;
    assign we        = r_we;
    assign re        = r_re;
    assign cmp_en    = r_cmp_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_q    = r_fail_q;

endmodule

// File: tb/tb_mbist_controller.sv
// Bench for mbist_controller: cycle-by-cycle reference schedule computed from pattern/phase arithmetic.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mbist_controller;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int PAT    = 2 * DEPTH + 1;
    localparam int TOTAL  = 6 * PAT;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              mismatch = 1'b0;
    logic [2:0]        q;
    logic [ADDR_W-1:0] addr;
    logic              we, re, cmp_en, busy, done, fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_q;

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;
    bit fault_map [6][DEPTH];

    mbist_controller #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mismatch  (mismatch),
        .q         (q),
        .addr      (addr),
        .we        (we),
        .re        (re),
        .cmp_en    (cmp_en),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_q    (fail_q)
    );

    always #5 clk = ~clk;

    // Structural invariants, sampled just after every rising edge
    logic prev_re = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_re = 1'b0;
        end else begin
            assert (q <= 3'd5) else begin
                $display("FAIL inv_q got=%0d need<=5", q);
                viol++;
            end
            assert (!(we && re)) else begin
                $display("FAIL inv_we_re got we=%b re=%b need not both 1", we, re);
                viol++;
            end
            assert (cmp_en === prev_re) else begin
                $display("FAIL inv_cmp_en got=%b need=%b", cmp_en, prev_re);
                viol++;
            end
            prev_re = re;
        end
    end

    function automatic bit noise_bit(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic clear_faults();
        for (int p = 0; p < 6; p++)
            for (int a = 0; a < DEPTH; a++)
                fault_map[p][a] = 1'b0;
    endtask

    task automatic add_random_faults(input int n);
        for (int i = 0; i < n; i++)
            fault_map[$urandom_range(0, 5)][$urandom_range(0, DEPTH - 1)] = 1'b1;
    endtask

    // One full test from IDLE; noise: 0 tied low, 1 tied high, 2 random (only off-compare cycles)
    task automatic run_bist(input bit hold_start, input int noise);
        int first_fc, e_fa, e_fq, p, r, ea;
        bit e_fail;
        logic [8:0] ev, gv;
        first_fc = TOTAL + 100;
        e_fa = 0;
        e_fq = 0;
        for (int pp = 0; pp < 6; pp++)
            for (int a = 0; a < DEPTH; a++)
                if (fault_map[pp][a] && first_fc > TOTAL) begin
                    first_fc = pp * PAT + DEPTH + 1 + a;
                    e_fa = a;
                    e_fq = pp;
                end

        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0 || re !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_before_start got busy=%b done=%b we=%b re=%b need 0000", busy, done, we, re);
        end
        start = 1'b1;
        mismatch = noise_bit(noise);

        for (int t = 0; t < TOTAL; t++) begin
            @(negedge clk);
            p = t / PAT;
            r = t % PAT;
            e_fail = (first_fc < t);
            ev = {r < DEPTH, (r >= DEPTH) && (r < 2 * DEPTH), r > DEPTH, 1'b1, 1'b0, e_fail, 3'(p)};
            gv = {we, re, cmp_en, busy, done, fail, q};
            n_tests++;
            if (gv !== ev) begin
                n_fail++;
                $display("FAIL cycle_ctrl t=%0d got {we,re,cmp,busy,done,fail,q}=%b need=%b", t, gv, ev);
            end
            if (r < 2 * DEPTH) begin
                ea = (r < DEPTH) ? r : r - DEPTH;
                n_tests++;
                if (addr !== ADDR_W'(ea)) begin
                    n_fail++;
                    $display("FAIL cycle_addr t=%0d got=%0d need=%0d", t, addr, ea);
                end
            end
            if (e_fail) begin
                n_tests++;
                if (fail_addr !== ADDR_W'(e_fa) || fail_q !== 3'(e_fq)) begin
                    n_fail++;
                    $display("FAIL cycle_fail_info t=%0d got addr=%0d q=%0d need addr=%0d q=%0d",
                             t, fail_addr, fail_q, e_fa, e_fq);
                end
            end
            start = 1'($urandom_range(0, 1));
            if (r > DEPTH) mismatch = fault_map[p][r - DEPTH - 1];
            else           mismatch = noise_bit(noise);
        end

        // Edge TOTAL has now passed: done must be up
        @(negedge clk);
        e_fail = (first_fc < TOTAL);
        n_tests++;
        if ({we, re, cmp_en, busy, done, fail} !== {5'b00001, e_fail}) begin
            n_fail++;
            $display("FAIL done_edge got {we,re,cmp,busy,done,fail}=%b need=%b",
                     {we, re, cmp_en, busy, done, fail}, {5'b00001, e_fail});
        end
        n_tests++;
        if (fail_addr !== ADDR_W'(e_fa) || fail_q !== 3'(e_fq)) begin
            n_fail++;
            $display("FAIL done_fail_info got addr=%0d q=%0d need addr=%0d q=%0d", fail_addr, fail_q, e_fa, e_fq);
        end
        start = hold_start;
        mismatch = noise_bit(noise);

        if (hold_start) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                n_tests++;
                if (done !== 1'b1 || busy !== 1'b0 || we !== 1'b0 || fail !== e_fail) begin
                    n_fail++;
                    $display("FAIL held_start_done i=%0d got done=%b busy=%b we=%b fail=%b need 1 0 0 %b",
                             i, done, busy, we, fail, e_fail);
                end
                mismatch = noise_bit(noise);
            end
            start = 1'b0;
        end

        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || fail !== e_fail) begin
            n_fail++;
            $display("FAIL back_to_idle got done=%b busy=%b fail=%b need 0 0 %b", done, busy, fail, e_fail);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({q, addr, we, re, cmp_en, busy, done, fail, fail_addr, fail_q} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got=%b need all zero",
                     {q, addr, we, re, cmp_en, busy, done, fail, fail_addr, fail_q});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start got busy=%b done=%b we=%b need 000", busy, done, we);
        end
    endtask

    task automatic test_clean_run();
        clear_faults();
        run_bist(1'b0, 0);
    endtask

    task automatic test_fail_capture();
        clear_faults();
        fault_map[2][9] = 1'b1;
        fault_map[4][3] = 1'b1;
        run_bist(1'b0, 2);
    endtask

    task automatic test_start_held();
        clear_faults();
        add_random_faults($urandom_range(1, 3));
        run_bist(1'b1, 2);
    endtask

    task automatic test_restart_clears();
        clear_faults();
        run_bist(1'b0, 1);
    endtask

    task automatic test_random_runs();
        for (int k = 0; k < 3; k++) begin
            clear_faults();
            add_random_faults($urandom_range(0, 3));
            run_bist(1'($urandom_range(0, 1)), 2);
        end
    endtask

    task automatic test_reset_mid_run();
        clear_faults();
        @(negedge clk);
        start = 1'b1;
        for (int t = 0; t < 3 * PAT + DEPTH + 5; t++) begin
            @(negedge clk);
            start = 1'b0;
            mismatch = (t == PAT + DEPTH + 1 + 7);
        end
        n_tests++;
        if (re !== 1'b1 || q !== 3'd3 || fail !== 1'b1 || fail_addr !== 4'd7 || fail_q !== 3'd1) begin
            n_fail++;
            $display("FAIL pre_reset_state got re=%b q=%0d fail=%b fa=%0d fq=%0d need 1 3 1 7 1",
                     re, q, fail, fail_addr, fail_q);
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({q, addr, we, re, cmp_en, busy, done, fail, fail_addr, fail_q} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got=%b need all zero",
                     {q, addr, we, re, cmp_en, busy, done, fail, fail_addr, fail_q});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++;
        if ({q, addr, we, re, cmp_en, busy, done, fail, fail_addr, fail_q} !== '0) begin
            n_fail++;
            $display("FAIL stay_idle_after_reset got=%b need all zero",
                     {q, addr, we, re, cmp_en, busy, done, fail, fail_addr, fail_q});
        end
    endtask

    task automatic test_assertions();
        n_tests++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL invariants got %0d violations need 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_fail_capture();
        test_start_held();
        test_restart_clears();
        test_random_runs();
        test_reset_mid_run();
        test_assertions();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
